wr_fifo_axi_drain: RTL and testbench

//  Read side of the 16->128-bit write prefetch FIFO. Pops 128-bit words and

---
 rtl/wr_fifo_axi_drain.sv | 164 ++++++++++++++++
 tb/tb_wr_fifo_axi_drain.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wr_fifo_axi_drain.sv
// wr_fifo_axi_drain
//   Read side of the 16->128-bit write prefetch FIFO. Pops FIFO words and issues
//   fixed-length AXI4 INCR write bursts into a circular frame buffer in DDR.
//   Single clock domain (FIFO read clock).
//
// Ports
//   rd_clk, rd_rst_n      clock, asynchronous active-low reset
//   frame_start           pulse: next burst restarts at BASE_ADDR
//   fifo_rd_en/vld/data   FIFO read port (prefetch style, head valid when vld=1)
//   axi_aw*               write address channel (awlen fixed to BURST_LEN-1)
//   axi_w*                write data channel (wstrb all ones)
//   axi_b*                write response channel
//   busy                  high whenever the FSM is not idle
//   wr_err                sticky error on non-OKAY bresp (only with BRESP_ERR_EN)
//
// Build option
//   BRESP_ERR_EN: when defined, adds the wr_err output and bresp checking.

module wr_fifo_axi_drain #(
    parameter int unsigned           ADDR_WIDTH  = 28,
    parameter int unsigned           DATA_WIDTH  = 128,
    parameter int unsigned           BURST_LEN   = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int unsigned           FRAME_BEATS = 8192
) (
    input  logic                    rd_clk,
    input  logic                    rd_rst_n,
    input  logic                    frame_start,
    output logic                    fifo_rd_en,
    input  logic                    fifo_rd_vld,
    input  logic [DATA_WIDTH-1:0]   fifo_rd_data,
    output logic [ADDR_WIDTH-1:0]   axi_awaddr,
    output logic [7:0]              axi_awlen,
    output logic                    axi_awvalid,
    input  logic                    axi_awready,
    output logic [DATA_WIDTH-1:0]   axi_wdata,
    output logic [DATA_WIDTH/8-1:0] axi_wstrb,
    output logic                    axi_wlast,
    output logic                    axi_wvalid,
    input  logic                    axi_wready,
    input  logic [1:0]              axi_bresp,
    input  logic                    axi_bvalid,
    output logic                    axi_bready,
    output logic                    busy
`ifdef BRESP_ERR_EN
    ,
    output logic                    wr_err
`endif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_AW   = 2'd1;
    localparam logic [1:0] ST_W    = 2'd2;
    localparam logic [1:0] ST_B    = 2'd3;

    localparam logic [ADDR_WIDTH-1:0] BURST_BYTES = ADDR_WIDTH'(BURST_LEN * DATA_WIDTH / 8);
    localparam logic [7:0]            LAST_BEAT   = 8'(BURST_LEN - 1);
    // Frame count value at which the current burst is the last of the frame
    localparam logic [31:0]           FRAME_LAST  = 32'(FRAME_BEATS - BURST_LEN);

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           frame_cnt_q, frame_cnt_d;
    logic [7:0]            beat_cnt_q, beat_cnt_d;
    logic                  start_pend_q, start_pend_d;
    logic                  w_hs;

    assign w_hs = (state_q == ST_W) && fifo_rd_vld && axi_wready;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        frame_cnt_d  = frame_cnt_q;
        beat_cnt_d   = beat_cnt_q;
        // frame_start is remembered in every state; only idle consumes it
        start_pend_d = start_pend_q | frame_start;
        case (state_q)
            ST_IDLE: begin
                // Same-cycle pulse is honoured too, so the very next AW uses BASE_ADDR
                if (start_pend_q || frame_start) begin
                    addr_d       = BASE_ADDR;
                    frame_cnt_d  = '0;
                    start_pend_d = 1'b0;
                end
                if (fifo_rd_vld) state_d = ST_AW;
            end
            ST_AW: begin
                if (axi_awready) state_d = ST_W;
            end
            ST_W: begin
                if (w_hs) begin
                    if (beat_cnt_q == LAST_BEAT) begin
                        beat_cnt_d = '0;
                        state_d    = ST_B;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 8'd1;
                    end
                end
            end
            default: begin
                if (axi_bvalid) begin
                    if (frame_cnt_q >= FRAME_LAST) begin
                        addr_d      = BASE_ADDR;
                        frame_cnt_d = '0;
                    end else begin
                        addr_d      = addr_q + BURST_BYTES;
                        frame_cnt_d = frame_cnt_q + 32'(BURST_LEN);
                    end
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            state_q      <= ST_IDLE;
            addr_q       <= BASE_ADDR;
            frame_cnt_q  <= '0;
            beat_cnt_q   <= '0;
            start_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            frame_cnt_q  <= frame_cnt_d;
            beat_cnt_q   <= beat_cnt_d;
            start_pend_q <= start_pend_d;
        end
    end

`ifdef BRESP_ERR_EN
    logic wr_err_q, wr_err_d;

    always_comb begin
        wr_err_d = wr_err_q;
        if (frame_start) wr_err_d = 1'b0;
        // An error response in the same cycle as frame_start is still reported
        if ((state_q == ST_B) && axi_bvalid && (axi_bresp != 2'b00)) wr_err_d = 1'b1;
    end

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) wr_err_q <= 1'b0;
        else           wr_err_q <= wr_err_d;
    end

    assign wr_err = wr_err_q;
`else
    logic unused_bresp;
    assign unused_bresp = ^axi_bresp;
`endif

    // All control outputs decode from state so an async reset clears them at once
    assign axi_awvalid = (state_q == ST_AW);
    assign axi_awaddr  = addr_q;
    assign axi_awlen   = LAST_BEAT;
    assign axi_wvalid  = (state_q == ST_W) && fifo_rd_vld;
    assign axi_wdata   = fifo_rd_data;
    assign axi_wstrb   = '1;
    assign axi_wlast   = (state_q == ST_W) && (beat_cnt_q == LAST_BEAT);
    assign axi_bready  = (state_q == ST_B);
    assign fifo_rd_en  = w_hs;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_wr_fifo_axi_drain.sv
// Directed testbench for wr_fifo_axi_drain (default parameters).
// The FIFO is an endless source whose head word carries a pop index, so beat
// order and pop counts can be checked against hand-computed values.
// Define BRESP_ERR_EN for both RTL and bench to exercise wr_err.

module tb_wr_fifo_axi_drain;

    localparam logic [95:0] PAT = 96'hC0FFEE00_5A5A5A5A_12345678;

    logic          rd_clk = 1'b0;
    logic          rd_rst_n;
    logic          frame_start;
    logic          fifo_rd_en;
    logic          fifo_rd_vld;
    logic [127:0]  fifo_rd_data;
    logic [27:0]   axi_awaddr;
    logic [7:0]    axi_awlen;
    logic          axi_awvalid;
    logic          axi_awready;
    logic [127:0]  axi_wdata;
    logic [15:0]   axi_wstrb;
    logic          axi_wlast;
    logic          axi_wvalid;
    logic          axi_wready;
    logic [1:0]    axi_bresp;
    logic          axi_bvalid;
    logic          axi_bready;
    logic          busy;
`ifdef BRESP_ERR_EN
    logic          wr_err;
`endif

    int unsigned   pop_idx = 0;
    int            errors = 0;
    int            checks = 0;

    always #5 rd_clk = ~rd_clk;

    assign fifo_rd_data = {PAT, pop_idx};

    always @(posedge rd_clk) if (fifo_rd_en && fifo_rd_vld) pop_idx <= pop_idx + 1;

    wr_fifo_axi_drain dut (
        .rd_clk       (rd_clk),
        .rd_rst_n     (rd_rst_n),
        .frame_start  (frame_start),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_vld  (fifo_rd_vld),
        .fifo_rd_data (fifo_rd_data),
        .axi_awaddr   (axi_awaddr),
        .axi_awlen    (axi_awlen),
        .axi_awvalid  (axi_awvalid),
        .axi_awready  (axi_awready),
        .axi_wdata    (axi_wdata),
        .axi_wstrb    (axi_wstrb),
        .axi_wlast    (axi_wlast),
        .axi_wvalid   (axi_wvalid),
        .axi_wready   (axi_wready),
        .axi_bresp    (axi_bresp),
        .axi_bvalid   (axi_bvalid),
        .axi_bready   (axi_bready),
        .busy         (busy)
`ifdef BRESP_ERR_EN
        ,
        .wr_err       (wr_err)
`endif
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge rd_clk);
        #1;
    endtask

    // mode 0: plain, 1: underrun after beat 5, 2: wready toggling,
    // 3: frame_start at beat 8, 4: frame_start in idle just before AW
    task automatic do_burst(input logic [27:0] exp_addr, input int mode, input bit detail,
                            input logic [1:0] resp);
        int unsigned base;
        int          k;
        int          n;
        int          stall;
        bit          got;
        bit          fs_done;
        base        = pop_idx;
        fifo_rd_vld = 1'b1;
        axi_awready = 1'b1;
        axi_wready  = 1'b0;
        axi_bvalid  = 1'b0;
        axi_bresp   = resp;
        got         = 1'b0;
        for (n = 0; n < 8 && !got; n++) begin
            frame_start = (mode == 4) && (n == 0);
            #1;
            if (axi_awvalid) begin
                got = 1'b1;
                chk("awaddr", axi_awaddr, exp_addr);
                chk("awlen", axi_awlen, 8'd15);
            end
            cyc();
        end
        frame_start = 1'b0;
        axi_awready = 1'b0;
        chk("aw_seen", got, 1'b1);
        k       = 0;
        n       = 0;
        stall   = 0;
        fs_done = 1'b0;
        while (k < 16 && n < 100) begin
            fifo_rd_vld = 1'b1;
            axi_wready  = 1'b1;
            if (mode == 1 && k == 5 && stall < 3) begin
                fifo_rd_vld = 1'b0;
                stall++;
            end
            if (mode == 2) axi_wready = (n % 2 == 0);
            frame_start = (mode == 3) && (k == 8) && !fs_done;
            if (frame_start) fs_done = 1'b1;
            #1;
            if (detail) begin
                chk("wvalid", axi_wvalid, fifo_rd_vld);
                chk("wlast", axi_wlast, k == 15);
                chk("rd_en", fifo_rd_en, fifo_rd_vld && axi_wready);
                chk("wstrb", axi_wstrb, 16'hFFFF);
            end
            if (axi_wvalid && axi_wready) begin
                if (detail) chk("wdata", axi_wdata, {PAT, base + k});
                k++;
            end
            cyc();
            n++;
        end
        frame_start = 1'b0;
        axi_wready  = 1'b0;
        chk("beats", k, 16);
        if (detail) chk("pops", pop_idx - base, 16);
        axi_bvalid = 1'b1;
        #1;
        chk("bready", axi_bready, 1'b1);
        cyc();
        axi_bvalid = 1'b0;
        #1;
        if (detail) chk("idle_busy", busy, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit got;
        rd_rst_n    = 1'b0;
        frame_start = 1'b0;
        fifo_rd_vld = 1'b1;
        axi_awready = 1'b0;
        axi_wready  = 1'b0;
        axi_bresp   = 2'b00;
        axi_bvalid  = 1'b0;
        repeat (2) cyc();
        chk("rst_awvalid", axi_awvalid, 1'b0);
        chk("rst_wvalid", axi_wvalid, 1'b0);
        chk("rst_wlast", axi_wlast, 1'b0);
        chk("rst_bready", axi_bready, 1'b0);
        chk("rst_rd_en", fifo_rd_en, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_awaddr", axi_awaddr, 28'h0);
`ifdef BRESP_ERR_EN
        chk("rst_wr_err", wr_err, 1'b0);
`endif
        @(negedge rd_clk);
        rd_rst_n = 1'b1;
        cyc();

        do_burst(28'h000, 0, 1'b1, 2'b00);
        do_burst(28'h100, 1, 1'b1, 2'b00);
        do_burst(28'h200, 2, 1'b1, 2'b00);
        do_burst(28'h300, 3, 1'b1, 2'b00);   // frame_start mid-burst
        do_burst(28'h000, 0, 1'b1, 2'b00);   // restarted frame
        do_burst(28'h000, 4, 1'b1, 2'b00);   // frame_start in idle, would be 0x100

        // Reset in the middle of a W phase at address 0x100
        fifo_rd_vld = 1'b1;
        axi_awready = 1'b1;
        axi_wready  = 1'b1;
        got         = 1'b0;
        for (int n = 0; n < 10 && !got; n++) begin
            #1;
            if (axi_wvalid) got = 1'b1;
            else cyc();
        end
        chk("midw_seen", got, 1'b1);
        chk("midw_addr", axi_awaddr, 28'h100);
        cyc();
        cyc();
        rd_rst_n = 1'b0;
        #1;
        chk("arst_awvalid", axi_awvalid, 1'b0);
        chk("arst_wvalid", axi_wvalid, 1'b0);
        chk("arst_wlast", axi_wlast, 1'b0);
        chk("arst_bready", axi_bready, 1'b0);
        chk("arst_rd_en", fifo_rd_en, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_awaddr", axi_awaddr, 28'h0);
        axi_awready = 1'b0;
        axi_wready  = 1'b0;
        @(negedge rd_clk);
        rd_rst_n = 1'b1;
        cyc();

        // Whole frame: 512 bursts of 256 bytes, then wrap to the base
        for (int i = 0; i < 513; i++) begin
            logic [27:0] exp;
            exp = (i == 512) ? 28'h0 : 28'(i * 256);
            do_burst(exp, 0, 1'b0, (i == 7) ? 2'b10 : 2'b00);
        end

`ifdef BRESP_ERR_EN
        do_burst(28'h100, 0, 1'b1, 2'b10);
        chk("err_set", wr_err, 1'b1);
        do_burst(28'h200, 0, 1'b1, 2'b00);
        chk("err_held", wr_err, 1'b1);
        fifo_rd_vld = 1'b0;
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        #1;
        chk("err_clr", wr_err, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
